// File: rtl/axis_cmd_gen_mm2s.sv
// MM2S command generator: replays a DDR buffer through an AXI DataMover by
// issuing bursts of at most MAX_BURST_LEN bytes, one-shot or looped.
module axis_cmd_gen_mm2s #(
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_LEN   = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [71:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_sts_tdata,
    input  logic        s_axis_sts_tvalid,
    output logic        s_axis_sts_tready,
    input  logic        read_start,
    input  logic        read_reset,
    input  logic        loop_en,
    input  logic [31:0] base_addr,
    input  logic [31:0] play_size,
    output logic        play_done,
    output logic        play_err,
    output logic [15:0] pass_cnt
);
    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]      BURST   = 32'(MAX_BURST_LEN);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [31:0]                r_base;
    logic [31:0]                r_size;
    logic [31:0]                r_addr;
    logic [31:0]                r_remaining;
    logic [OUT_W-1:0]           r_outstanding;
    logic [MAX_OUTSTANDING-1:0] r_eof_q;
    logic [71:0]                r_tdata;
    logic                       r_tvalid;
    logic                       r_sts_ready;
    logic                       r_play_done;
    logic                       r_play_err;
    logic [15:0]                r_pass_cnt;

    logic                       w_cmd_hs;
    logic                       w_sts_hs;
    logic                       w_sts_ok;
    logic                       w_err;
    logic                       w_final_hs;
    logic                       w_wrap;
    logic                       w_load;
    logic                       w_eof;
    logic [31:0]                w_src_addr;
    logic [31:0]                w_src_rem;
    logic [31:0]                w_len;
    logic [OUT_W-1:0]           w_out_next;
    logic [OUT_W-1:0]           w_push_idx;
    logic [71:0]                w_cmd;
    logic [MAX_OUTSTANDING-1:0] w_eof_q_next;
    logic                       w_unused_tag;

    assign w_unused_tag = ^s_axis_sts_tdata[3:0];

    // The loop wrap is folded into the chunk source so the first chunk of the
    // next pass can be loaded in the same cycle as the final-chunk handshake.
    always_comb begin
        w_cmd_hs     = r_tvalid & m_axis_tready;
        w_sts_hs     = r_sts_ready & s_axis_sts_tvalid & (r_outstanding != '0);
        w_sts_ok     = s_axis_sts_tdata[7] & ~|s_axis_sts_tdata[6:4];
        w_err        = w_sts_hs & ~w_sts_ok;
        w_final_hs   = w_cmd_hs & r_tdata[30];
        w_wrap       = (r_state == ISSUE) & w_final_hs & loop_en & ~w_err;
        w_out_next   = r_outstanding + OUT_W'(w_cmd_hs) - OUT_W'(w_sts_hs);
        w_src_addr   = w_wrap ? r_base : r_addr;
        w_src_rem    = w_wrap ? r_size : r_remaining;
        w_eof        = (w_src_rem <= BURST);
        w_len        = w_eof ? w_src_rem : BURST;
        w_load       = (r_state == ISSUE) & ~w_err & (~r_tvalid | w_cmd_hs) &
                       (w_src_rem != '0) & (w_out_next < OUT_MAX);

        w_cmd                  = '0;
        w_cmd[63:32]           = w_src_addr;
        w_cmd[30]              = w_eof;
        w_cmd[23]              = 1'b1;
        w_cmd[BTT_WIDTH-1:0]   = w_len[BTT_WIDTH-1:0];

        w_eof_q_next = r_eof_q;
        if (w_sts_hs)
            w_eof_q_next = r_eof_q >> 1;
        w_push_idx = r_outstanding - OUT_W'(w_sts_hs);
        if (w_cmd_hs) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (OUT_W'(i) == w_push_idx)
                    w_eof_q_next[i] = r_tdata[30];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:
                if (read_start & ~r_play_done & ~r_play_err)
                    w_state_next = (play_size == '0) ? DONE : ISSUE;
            ISSUE:
                if (w_err | (w_final_hs & ~loop_en))
                    w_state_next = DRAIN;
            DRAIN:
                if ((r_outstanding == '0) & ~r_tvalid)
                    w_state_next = DONE;
            DONE:
                w_state_next = DONE;
            default:
                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else if (read_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base        <= '0;
            r_size        <= '0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_eof_q       <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_sts_ready   <= 1'b0;
            r_play_done   <= 1'b0;
            r_play_err    <= 1'b0;
            r_pass_cnt    <= '0;
        end else if (read_reset) begin
            r_base        <= '0;
            r_size        <= '0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_eof_q       <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_sts_ready   <= 1'b0;
            r_play_done   <= 1'b0;
            r_play_err    <= 1'b0;
            r_pass_cnt    <= '0;
        end else begin
            r_sts_ready   <= 1'b1;
            r_outstanding <= w_out_next;
            r_eof_q       <= w_eof_q_next;
            if (w_sts_hs & w_sts_ok & r_eof_q[0])
                r_pass_cnt <= r_pass_cnt + 16'd1;
            if (w_err)
                r_play_err <= 1'b1;
            if (r_state == DONE)
                r_play_done <= 1'b1;
            if ((r_state == IDLE) && (w_state_next != IDLE)) begin
                r_base      <= base_addr;
                r_size      <= play_size;
                r_addr      <= base_addr;
                r_remaining <= play_size;
            end
            if (w_wrap) begin
                r_addr      <= r_base;
                r_remaining <= r_size;
            end
            // addr/remaining always point at the next chunk still to be loaded.
            if (w_load) begin
                r_tdata     <= w_cmd;
                r_tvalid    <= 1'b1;
                r_addr      <= w_src_addr + w_len;
                r_remaining <= w_src_rem - w_len;
            end else if (w_cmd_hs) begin
                r_tvalid    <= 1'b0;
            end
        end
    end

    assign m_axis_tdata      = r_tdata;
    assign m_axis_tvalid     = r_tvalid;
    assign s_axis_sts_tready = r_sts_ready;
    assign play_done         = r_play_done;
    assign play_err          = r_play_err;
    assign pass_cnt          = r_pass_cnt;

endmodule

// File: tb/tb_axis_cmd_gen_mm2s.sv
// Bench for axis_cmd_gen_mm2s: a chunk-level model predicts every command word
// and pass count while a responder returns DataMover statuses.
module tb_axis_cmd_gen_mm2s;
    localparam int MAX_BURST_LEN   = 4096;
    localparam int MAX_OUTSTANDING = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [71:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;
    logic        read_start;
    logic        read_reset;
    logic        loop_en;
    logic [31:0] base_addr;
    logic [31:0] play_size;
    logic        play_done;
    logic        play_err;
    logic [15:0] pass_cnt;

    int checks = 0;
    int fails  = 0;

    bit          modelActive = 0;
    logic [31:0] mBase, mSize, mAddr, mRem;
    int          cmdCount = 0;
    int          benchOut = 0;
    int          expPass  = 0;
    bit          eofQ[$];
    bit          errSeen  = 0;
    int          errAllow = 0;
    logic [71:0] capt [8];

    bit readyRandom = 0;
    bit readyLevel  = 1;
    bit cmdTaken    = 0;
    bit stsTaken    = 0;
    bit stsHold     = 0;
    bit stsFlush    = 0;
    int stsCredits  = 0;
    int errSeqSel   = 0;

    axis_cmd_gen_mm2s #(
        .BTT_WIDTH      (23),
        .MAX_BURST_LEN  (MAX_BURST_LEN),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .s_axis_sts_tdata (s_axis_sts_tdata),
        .s_axis_sts_tvalid(s_axis_sts_tvalid),
        .s_axis_sts_tready(s_axis_sts_tready),
        .read_start       (read_start),
        .read_reset       (read_reset),
        .loop_en          (loop_en),
        .base_addr        (base_addr),
        .play_size        (play_size),
        .play_done        (play_done),
        .play_err         (play_err),
        .pass_cnt         (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [71:0] expWord(input logic [31:0] addr, input logic [31:0] rem);
        logic [71:0] w;
        logic [31:0] n;
        n        = (rem > 32'(MAX_BURST_LEN)) ? 32'(MAX_BURST_LEN) : rem;
        w        = '0;
        w[63:32] = addr;
        w[30]    = (rem <= 32'(MAX_BURST_LEN));
        w[23]    = 1'b1;
        w[22:0]  = n[22:0];
        return w;
    endfunction

    // Handshakes are judged at the falling edge: whatever is valid&ready here
    // transfers on the next rising edge.
    initial begin : compareProc
        bit          stalled;
        logic [71:0] stallData;
        bit          eofFlag;
        bit          okFlag;
        bit          allowed;
        stalled   = 0;
        stallData = '0;
        forever begin
            @(negedge clk);
            cmdTaken = 0;
            stsTaken = 0;
            if (!resetn || read_reset) begin
                stalled     = 0;
                modelActive = 0;
                benchOut    = 0;
                eofQ.delete();
                errSeen     = 0;
                errAllow    = 0;
                cmdCount    = 0;
                expPass     = 0;
            end else begin
                if (stalled) begin
                    checkOutput("tdata_stable", m_axis_tdata, stallData);
                    checkOutput("tvalid_held", 72'(m_axis_tvalid), 72'd1);
                end
                if (s_axis_sts_tvalid && s_axis_sts_tready) begin
                    stsTaken = 1;
                    if (benchOut > 0) begin
                        benchOut--;
                        eofFlag = eofQ.pop_front();
                        okFlag  = s_axis_sts_tdata[7] && (s_axis_sts_tdata[6:4] == 3'b000);
                        if (eofFlag && okFlag)
                            expPass++;
                        if (!okFlag && !errSeen) begin
                            errSeen  = 1;
                            errAllow = m_axis_tvalid ? 1 : 0;
                        end
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    cmdTaken = 1;
                    allowed  = modelActive && (!errSeen || errAllow > 0);
                    checkOutput("cmd_expected", 72'(allowed), 72'd1);
                    if (allowed) begin
                        if (errSeen)
                            errAllow--;
                        checkOutput("cmd_word", m_axis_tdata, expWord(mAddr, mRem));
                        if (cmdCount < 8)
                            capt[cmdCount] = m_axis_tdata;
                        cmdCount++;
                        benchOut++;
                        checkOutput("outstanding_bound", 72'(benchOut <= MAX_OUTSTANDING), 72'd1);
                        eofQ.push_back(mRem <= 32'(MAX_BURST_LEN));
                        if (mRem <= 32'(MAX_BURST_LEN)) begin
                            if (loop_en && !errSeen) begin
                                mAddr = mBase;
                                mRem  = mSize;
                            end else begin
                                modelActive = 0;
                            end
                        end else begin
                            mAddr = mAddr + 32'(MAX_BURST_LEN);
                            mRem  = mRem - 32'(MAX_BURST_LEN);
                        end
                    end
                end
                stalled   = m_axis_tvalid && !m_axis_tready;
                stallData = m_axis_tdata;
            end
        end
    end

    // Returns one status per accepted command about two cycles later; command
    // number errSeqSel gets SLVERR, and stsHold/stsCredits meter the release.
    initial begin : statusResponder
        int dueQ[$];
        int seqQ[$];
        int cyc;
        int cmdSeq;
        cyc    = 0;
        cmdSeq = 0;
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tdata  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (stsFlush || !resetn) begin
                dueQ.delete();
                seqQ.delete();
                cmdSeq = 0;
                s_axis_sts_tvalid = 1'b0;
            end else begin
                if (stsTaken)
                    s_axis_sts_tvalid = 1'b0;
                if (cmdTaken) begin
                    cmdSeq++;
                    dueQ.push_back(cyc + 2);
                    seqQ.push_back(cmdSeq);
                end
                if (!s_axis_sts_tvalid && dueQ.size() > 0 && dueQ[0] <= cyc && (!stsHold || stsCredits > 0)) begin
                    if (stsHold)
                        stsCredits--;
                    s_axis_sts_tvalid = 1'b1;
                    s_axis_sts_tdata  = (seqQ[0] == errSeqSel) ? 8'h40 : 8'h80;
                    void'(dueQ.pop_front());
                    void'(seqQ.pop_front());
                end
            end
        end
    end

    initial begin : readyDriver
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] s, input logic lp);
        @(posedge clk);
        #1;
        base_addr   = b;
        play_size   = s;
        loop_en     = lp;
        mBase       = b;
        mSize       = s;
        mAddr       = b;
        mRem        = s;
        modelActive = (s != 0);
        read_start  = 1'b1;
        @(posedge clk);
        #1;
        read_start  = 1'b0;
    endtask

    task automatic checkZeroOutputs(input string pfx);
        checkOutput({pfx, "_tvalid"},    72'(m_axis_tvalid), 72'd0);
        checkOutput({pfx, "_tdata"},     m_axis_tdata, 72'd0);
        checkOutput({pfx, "_sts_tready"}, 72'(s_axis_sts_tready), 72'd0);
        checkOutput({pfx, "_done"},      72'(play_done), 72'd0);
        checkOutput({pfx, "_err"},       72'(play_err), 72'd0);
        checkOutput({pfx, "_pass_cnt"},  72'(pass_cnt), 72'd0);
    endtask

    task automatic softReset();
        @(posedge clk);
        #1;
        read_reset  = 1'b1;
        stsFlush    = 1'b1;
        readyRandom = 1'b0;
        loop_en     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkZeroOutputs("soft_reset");
        @(posedge clk);
        #1;
        read_reset = 1'b0;
        stsFlush   = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!play_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_within_budget", 72'(play_done), 72'd1);
        @(negedge clk);
    endtask

    initial begin : mainSeq
        int n;
        resetn     = 1'b0;
        read_start = 1'b0;
        read_reset = 1'b0;
        loop_en    = 1'b0;
        base_addr  = '0;
        play_size  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkZeroOutputs("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("[TB] one-shot 10000 bytes");
        applyStimulus(32'h1000_0000, 32'd10000, 1'b0);
        waitDone(300);
        checkOutput("s1_cmd_count", 72'(cmdCount), 72'd3);
        checkOutput("s1_cmd0", capt[0], 72'h00_10000000_00801000);
        checkOutput("s1_cmd1", capt[1], 72'h00_10001000_00801000);
        checkOutput("s1_cmd2", capt[2], 72'h00_10002000_40800710);
        checkOutput("s1_pass_cnt", 72'(pass_cnt), 72'd1);
        checkOutput("s1_pass_model", 72'(pass_cnt), 72'(expPass));
        checkOutput("s1_err", 72'(play_err), 72'd0);

        $display("[TB] outstanding limit with statuses withheld");
        softReset();
        stsHold    = 1'b1;
        stsCredits = 0;
        applyStimulus(32'h3000_0000, 32'd32768, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("s2_cmds_at_limit", 72'(cmdCount), 72'd4);
        checkOutput("s2_tvalid_blocked", 72'(m_axis_tvalid), 72'd0);
        @(posedge clk);
        #1;
        stsCredits = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_axis_sts_tvalid && s_axis_sts_tready) && n < 10);
        checkOutput("s2_status_released", 72'(s_axis_sts_tvalid && s_axis_sts_tready), 72'd1);
        @(negedge clk);
        checkOutput("s2_refill_latency", 72'(m_axis_tvalid), 72'd1);
        @(negedge clk);
        checkOutput("s2_limit_again", 72'(m_axis_tvalid), 72'd0);
        checkOutput("s2_cmds_after_release", 72'(cmdCount), 72'd5);
        stsHold = 1'b0;
        waitDone(500);
        checkOutput("s2_cmd_total", 72'(cmdCount), 72'd8);
        checkOutput("s2_pass_cnt", 72'(pass_cnt), 72'd1);

        $display("[TB] loop playback 8192 bytes");
        softReset();
        applyStimulus(32'h2000_0000, 32'd8192, 1'b1);
        n = 0;
        while (cmdCount < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s3_loop_progress", 72'(cmdCount >= 5), 72'd1);
        @(posedge clk);
        #1;
        loop_en = 1'b0;
        waitDone(500);
        checkOutput("s3_addr0", 72'(capt[0][63:32]), 72'h2000_0000);
        checkOutput("s3_addr1", 72'(capt[1][63:32]), 72'h2000_1000);
        checkOutput("s3_addr2", 72'(capt[2][63:32]), 72'h2000_0000);
        checkOutput("s3_addr3", 72'(capt[3][63:32]), 72'h2000_1000);
        checkOutput("s3_pass_vs_cmds", 72'(pass_cnt), 72'(cmdCount / 2));
        checkOutput("s3_pass_model", 72'(pass_cnt), 72'(expPass));

        $display("[TB] random tready 20000 bytes");
        softReset();
        readyRandom = 1'b1;
        applyStimulus(32'h4000_0100, 32'd20000, 1'b0);
        waitDone(2000);
        readyRandom = 1'b0;
        checkOutput("s4_cmd_total", 72'(cmdCount), 72'd5);
        checkOutput("s4_pass_cnt", 72'(pass_cnt), 72'd1);

        $display("[TB] SLVERR on second command");
        softReset();
        errSeqSel = 2;
        applyStimulus(32'h5000_0000, 32'd32768, 1'b0);
        waitDone(500);
        errSeqSel = 0;
        checkOutput("s5_err", 72'(play_err), 72'd1);
        checkOutput("s5_pass_cnt", 72'(pass_cnt), 72'd0);
        checkOutput("s5_tvalid", 72'(m_axis_tvalid), 72'd0);
        checkOutput("s5_cmds_stopped", 72'(cmdCount < 8), 72'd1);

        $display("[TB] read_reset mid-transfer");
        softReset();
        applyStimulus(32'h6000_0000, 32'd32768, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("s6_busy_before_reset", 72'(m_axis_tvalid || cmdCount > 0), 72'd1);
        softReset();

        $display("[TB] zero-length buffer");
        applyStimulus(32'h7000_0000, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("s7_done_one_cycle", 72'(play_done), 72'd0);
        checkOutput("s7_tvalid_one_cycle", 72'(m_axis_tvalid), 72'd0);
        @(negedge clk);
        checkOutput("s7_done_two_cycles", 72'(play_done), 72'd1);
        checkOutput("s7_tvalid_two_cycles", 72'(m_axis_tvalid), 72'd0);
        repeat (3) @(negedge clk);
        checkOutput("s7_no_cmds", 72'(cmdCount), 72'd0);
        checkOutput("s7_done_held", 72'(play_done), 72'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_cmd_gen_mm2s.md
Name: axis_cmd_gen_mm2s

Overview:
- Read-side counterpart of the S2MM capture command generator: issues AXI DataMover MM2S commands that replay a DDR buffer as an AXI-Stream (e.g. DAC playback).
- Splits the buffer at base_addr/play_size into bursts of at most MAX_BURST_LEN bytes.
- Consumes the DataMover MM2S status stream, limits outstanding commands, and flags completion and errors.
- Supports one-shot and continuous loop playback.

Parameters:
- BTT_WIDTH, 23, width of the BTT field in the command word.
- MAX_BURST_LEN, 4096, maximum bytes per command.
- MAX_OUTSTANDING, 4, maximum commands accepted but without a returned status (1..15).

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous active-low reset.
- m_axis_tdata  out  72  MM2S command word.
- m_axis_tvalid  out  1  command valid.
- m_axis_tready  in  1  DataMover command ready.
- s_axis_sts_tdata  in  8  MM2S status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG (ignored).
- s_axis_sts_tvalid  in  1  status valid.
- s_axis_sts_tready  out  1  status ready.
- read_start  in  1  level; starts playback while in IDLE.
- read_reset  in  1  synchronous soft reset.
- loop_en  in  1  1 = wrap to base_addr after each pass.
- base_addr  in  32  buffer start byte address; sampled at start.
- play_size  in  32  buffer length in bytes; sampled at start.
- play_done  out  1  sticky; pass complete and all statuses returned.
- play_err  out  1  sticky; a bad status was received.
- pass_cnt  out  16  completed passes, wraps at 0xFFFF.

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0, state IDLE, all counters 0.
- read_reset high: same values as reset, taking effect on the next edge. It overrides every other input and aborts mid-transfer; commands already accepted by the DataMover are not tracked after this.
- s_axis_sts_tready is 1 in every state outside reset and read_reset. Statuses are always drained.
- Command word fields:
  - [71:64] = 0.
  - [63:32] = current address.
  - [31] = 0 (MM2S).
  - [30] EOF = 1 only on the final chunk of a pass.
  - [29:24] = 0.
  - [23] SOF = 1.
  - [22:0] = chunk BTT.
- Chunk BTT = min(remaining, MAX_BURST_LEN), truncated to BTT_WIDTH.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Transition when read_start=1, play_done=0 and play_err=0.
  - Latch base_addr and play_size; addr=base_addr; remaining=play_size.
  - play_size=0: go to DONE, set play_done next cycle, issue no commands.
  - Otherwise go to ISSUE.
- ISSUE:
  - m_axis_tdata/m_axis_tvalid are registered. tdata is stable while tvalid=1; tvalid never drops without a handshake.
  - New command is presented only when the outstanding count after this cycle is below MAX_OUTSTANDING.
  - Back-to-back issue is allowed: a new command may be loaded in the same cycle as the previous handshake.
  - On each handshake: addr += BTT; remaining -= BTT; outstanding += 1.
  - Handshake on the final chunk with loop_en=1: addr=base, remaining=size, stay in ISSUE.
  - Handshake on the final chunk with loop_en=0: go to DRAIN.
  - loop_en is sampled only at the final-chunk handshake.
- Outstanding counter:
  - +1 per command handshake, -1 per status handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - A status arriving at count 0 is ignored; the counter saturates at 0.
- Pass accounting: pass_cnt increments when the status for a final chunk (EOF) returns OKAY. A per-outstanding-slot EOF flag FIFO of depth MAX_OUTSTANDING tracks which statuses correspond to EOF chunks.
- Error:
  - Condition: any status with [7]=0 or any of [6:4]=1.
  - Effect: play_err=1, tvalid deasserts after the current handshake completes (or immediately if tvalid=0), go to DRAIN.
- DRAIN: wait for outstanding=0, then go to DONE.
- DONE:
  - play_done=1 (also set after an error drain).
  - Hold until read_reset; read_start is ignored.

Test Plan:
- base=0x1000_0000, size=10000, loop_en=0, tready=1, one status returned 3 cycles after each command -> three commands:
  - addr 0x1000_0000, BTT 4096, EOF 0.
  - addr 0x1000_1000, BTT 4096, EOF 0.
  - addr 0x1000_2000, BTT 1808, EOF 1.
  - Then play_done=1 and pass_cnt=1.
- MAX_OUTSTANDING=4, size=32768, statuses withheld -> exactly 4 commands accepted, tvalid stays 0. Releasing one status lets one more command out within 1 cycle.
- loop_en=1, size=8192 -> addresses repeat base, base+0x1000, base, ... After loop_en drops mid-pass, the pass finishes, then DRAIN, then play_done; pass_cnt equals the completed passes.
- tready toggled randomly -> tdata is never changed while tvalid=1 and tready=0.
- Status 0x40 (SLVERR) on the 2nd command -> play_err=1, no new commands, play_done after outstanding reaches 0.
- size=0 -> no tvalid, play_done=1 two cycles after read_start. read_reset mid-ISSUE -> all outputs 0 next cycle.
